// File: rtl/input_ctrl_pkg.sv
// Shared types and parameter limits for the multi-channel input controller.
package input_ctrl_pkg;

  localparam int unsigned N_CH_MIN     = 1;
  localparam int unsigned N_CH_MAX     = 16;
  localparam int unsigned DEBOUNCE_MIN = 1;
  localparam int unsigned DEBOUNCE_MAX = 255;
  localparam int unsigned DB_CNT_W     = 8;

  typedef enum logic [1:0] {
    WAIT_LEVEL  = 2'd0,
    WAIT_RISE   = 2'd1,
    WAIT_FALL   = 2'd2,
    WAIT_STICKY = 2'd3
  } wait_mode_t;

endpackage

// File: rtl/input_debouncer.sv
// One channel: 2-flop synchronizer, debounce counter, stable level and its edges.
module input_debouncer
  import input_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic stable,
  output logic rise,
  output logic fall
);

  logic                sync1_q, sync1_d;
  logic                sync2_q, sync2_d;
  logic                stable_q, stable_d;
  logic                stable_p_q, stable_p_d;
  logic [DB_CNT_W-1:0] cnt_q, cnt_d;

  // Counter only runs while the synchronized input disagrees with the accepted level.
  always_comb begin
    sync1_d    = din;
    sync2_d    = sync1_q;
    stable_p_d = stable_q;
    stable_d   = stable_q;
    cnt_d      = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == DB_CNT_W'(DEBOUNCE - 1)) begin
        stable_d = ~stable_q;
      end else begin
        cnt_d = cnt_q + DB_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      stable_q   <= 1'b0;
      stable_p_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      stable_q   <= stable_d;
      stable_p_q <= stable_p_d;
      cnt_q      <= cnt_d;
    end
  end

  assign stable = stable_q;
  assign rise   = stable_q & ~stable_p_q;
  assign fall   = ~stable_q & stable_p_q;

endmodule

// File: rtl/input_controller_mc.sv
// Debounced multi-channel handshake inputs with sticky events, data capture and wait-driven PC enable.
module input_controller_mc
  import input_ctrl_pkg::*;
#(
  parameter  int unsigned BUS_WIDTH = 8,
  parameter  int unsigned N_CH      = 4,
  parameter  int unsigned DEBOUNCE  = 4,
  localparam int unsigned WCH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_CH-1:0]      ready_in,
  input  logic [BUS_WIDTH-1:0] data_in,
  input  logic                 f_wait,
  input  logic [WCH_W-1:0]     wait_ch,
  input  wait_mode_t           wait_mode,
  input  logic                 wait_value,
  output logic [N_CH-1:0]      pattern_match,
  output logic [N_CH-1:0]      event_pending,
  output logic [BUS_WIDTH-1:0] data_out,
  output logic                 PC_en
);

  logic [N_CH-1:0]      stable_w, rise_w, fall_w;
  logic [N_CH-1:0]      event_pending_q, event_pending_d;
  logic [N_CH-1:0]      consume_c;
  logic [BUS_WIDTH-1:0] data_out_q, data_out_d;
  logic                 ch_ok_c, cond_c, sel_rise_c;

  for (genvar i = 0; i < int'(N_CH); i++) begin : g_ch
    input_debouncer #(.DEBOUNCE(DEBOUNCE)) u_deb (
      .clk    (clk),
      .rst    (rst),
      .din    (ready_in[i]),
      .stable (stable_w[i]),
      .rise   (rise_w[i]),
      .fall   (fall_w[i])
    );
  end

  // Wait condition for the selected channel; out-of-range channels never satisfy it.
  always_comb begin
    ch_ok_c    = 32'(wait_ch) < N_CH;
    cond_c     = 1'b0;
    sel_rise_c = 1'b0;
    consume_c  = '0;
    if (ch_ok_c) begin
      sel_rise_c = rise_w[wait_ch];
      case (wait_mode)
        WAIT_LEVEL:  cond_c = stable_w[wait_ch];
        WAIT_RISE:   cond_c = rise_w[wait_ch];
        WAIT_FALL:   cond_c = fall_w[wait_ch];
        WAIT_STICKY: cond_c = event_pending_q[wait_ch];
        default:     cond_c = 1'b0;
      endcase
      if (f_wait && (wait_mode == WAIT_STICKY) && wait_value && cond_c) begin
        consume_c[wait_ch] = 1'b1;
      end
    end
    // A new rise wins over a simultaneous consume.
    event_pending_d = (event_pending_q & ~consume_c) | rise_w;
    data_out_d      = sel_rise_c ? data_in : data_out_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      event_pending_q <= '0;
      data_out_q      <= '0;
    end else begin
      event_pending_q <= event_pending_d;
      data_out_q      <= data_out_d;
    end
  end

  assign pattern_match = rise_w;
  assign event_pending = event_pending_q;
  assign data_out      = data_out_q;
  assign PC_en         = ~(f_wait & (cond_c ^ wait_value));

endmodule

// File: tb/tb_input_controller_mc.sv
// Randomized and directed bench for input_controller_mc with a scoreboard-checked reference model.
module tb_input_controller_mc;
  import input_ctrl_pkg::*;

  localparam int unsigned BW  = 8;
  localparam int unsigned NC  = 4;
  localparam int unsigned DEB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [NC-1:0] ready_in;
  logic [BW-1:0] data_in;
  logic          f_wait;
  logic [1:0]    wait_ch;
  wait_mode_t    wait_mode;
  logic          wait_value;
  logic [NC-1:0] pattern_match;
  logic [NC-1:0] event_pending;
  logic [BW-1:0] data_out;
  logic          PC_en;

  input_controller_mc #(.BUS_WIDTH(BW), .N_CH(NC), .DEBOUNCE(DEB)) dut (
    .clk           (clk),
    .rst           (rst),
    .ready_in      (ready_in),
    .data_in       (data_in),
    .f_wait        (f_wait),
    .wait_ch       (wait_ch),
    .wait_mode     (wait_mode),
    .wait_value    (wait_value),
    .pattern_match (pattern_match),
    .event_pending (event_pending),
    .data_out      (data_out),
    .PC_en         (PC_en)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: per channel, the level seen two edges after sampling is accepted
  // once it has disagreed with the accepted level for DEB consecutive edges.
  logic [NC-1:0] m_s1, m_s2, m_stab, m_stp, m_pend;
  int            m_run [NC];
  logic [BW-1:0] m_data;
  bit            m_valid = 1'b0;

  typedef struct {
    logic [NC-1:0] pm;
    logic [NC-1:0] ep;
    logic [BW-1:0] dout;
    logic          pc;
  } exp_t;
  exp_t exp_q[$];

  function automatic logic [NC-1:0] m_rise();
    return m_stab & ~m_stp;
  endfunction

  function automatic logic m_cond();
    logic [NC-1:0] fl;
    fl = ~m_stab & m_stp;
    if (int'(wait_ch) >= int'(NC)) return 1'b0;
    case (wait_mode)
      WAIT_LEVEL:  return m_stab[wait_ch];
      WAIT_RISE:   return m_rise() >> wait_ch;
      WAIT_FALL:   return fl[wait_ch];
      default:     return m_pend[wait_ch];
    endcase
  endfunction

  task automatic push_expect();
    exp_t e;
    if (!m_valid) return;
    e.pm   = m_rise();
    e.ep   = m_pend;
    e.dout = m_data;
    e.pc   = !(f_wait && (m_cond() != wait_value));
    exp_q.push_back(e);
  endtask

  task automatic model_edge();
    logic [NC-1:0] r, cons;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_stab = '0; m_stp = '0; m_pend = '0; m_data = '0;
      for (int i = 0; i < int'(NC); i++) m_run[i] = 0;
      m_valid = 1'b1;
      return;
    end
    if (!m_valid) return;
    r    = m_rise();
    cons = '0;
    if (f_wait && wait_mode == WAIT_STICKY && wait_value && m_cond()) cons[wait_ch] = 1'b1;
    if (r[wait_ch]) m_data = data_in;
    m_pend = (m_pend & ~cons) | r;
    for (int i = 0; i < int'(NC); i++) begin
      m_stp[i] = m_stab[i];
      if (m_s2[i] != m_stab[i]) begin
        m_run[i]++;
        if (m_run[i] == int'(DEB)) begin
          m_stab[i] = ~m_stab[i];
          m_run[i]  = 0;
        end
      end else begin
        m_run[i] = 0;
      end
      m_s2[i] = m_s1[i];
      m_s1[i] = ready_in[i];
    end
  endtask

  // One clock cycle with the currently driven inputs; returns 1 time unit after the edge.
  task automatic cyc();
    push_expect();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("sb_pattern_match", 32'(pattern_match), 32'(e.pm));
      chk("sb_event_pending", 32'(event_pending), 32'(e.ep));
      chk("sb_data_out", 32'(data_out), 32'(e.dout));
      chk("sb_PC_en", 32'(PC_en), 32'(e.pc));
    end
  end

  initial begin
    int  first;
    bit  saw, found;
    rst = 1'b1; ready_in = '0; data_in = '0; f_wait = 1'b0; wait_ch = '0;
    wait_mode = WAIT_LEVEL; wait_value = 1'b0;
    @(posedge clk); #1;
    cycles(2);
    chk("reset_pattern_match", 32'(pattern_match), 32'h0);
    chk("reset_event_pending", 32'(event_pending), 32'h0);
    chk("reset_data_out", 32'(data_out), 32'h0);
    rst = 1'b0;
    cycles(3);
    chk("reset_pc_en_nowait", 32'(PC_en), 32'h1);
    f_wait = 1'b1; wait_value = 1'b1; #1;
    chk("reset_pc_en_wait", 32'(PC_en), 32'h0);
    f_wait = 1'b0; wait_value = 1'b0;

    // Latency: high sampled at edge 1 gives a pulse right after edge 2+DEB.
    ready_in[0] = 1'b1;
    first = -1;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      if (first < 0 && pattern_match[0]) first = k;
    end
    chk("latency_ch0_edge", 32'(first), 32'(2 + DEB));

    // Short glitch is filtered.
    ready_in[1] = 1'b1;
    saw = 1'b0;
    for (int k = 0; k < 3; k++) begin cyc(); saw |= pattern_match[1] | event_pending[1]; end
    ready_in[1] = 1'b0;
    for (int k = 0; k < 12; k++) begin cyc(); saw |= pattern_match[1] | event_pending[1]; end
    chk("glitch_ch1_ignored", 32'(saw), 32'h0);

    // Sticky wait on channel 2 completes and consumes the event.
    f_wait = 1'b1; wait_mode = WAIT_STICKY; wait_ch = 2'd2; wait_value = 1'b1;
    cycles(2);
    chk("sticky_pc_en_blocked", 32'(PC_en), 32'h0);
    ready_in[2] = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      cyc();
      if (event_pending[2]) found = 1'b1;
    end
    chk("sticky_pending_seen", 32'(found), 32'h1);
    chk("sticky_pc_en_release", 32'(PC_en), 32'h1);
    cyc();
    chk("sticky_consumed", 32'(event_pending[2]), 32'h0);
    chk("sticky_pc_en_reblocked", 32'(PC_en), 32'h0);

    // Rise and consume in the same cycle keep the flag set.
    f_wait = 1'b0; ready_in[2] = 1'b0; cycles(10);
    ready_in[2] = 1'b1; cycles(10);
    chk("pending_without_wait", 32'(event_pending[2]), 32'h1);
    ready_in[2] = 1'b0; cycles(10);
    ready_in[2] = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (pattern_match[2]) begin
        f_wait = 1'b1;
        cyc();
        chk("rise_beats_consume", 32'(event_pending[2]), 32'h1);
        found = 1'b1;
      end else begin
        cyc();
      end
    end
    chk("rise_ch2_seen", 32'(found), 32'h1);
    cyc();
    chk("second_consume_clears", 32'(event_pending[2]), 32'h0);
    f_wait = 1'b0;

    // Data capture on selected-channel rise only.
    wait_ch = 2'd3; data_in = 8'h11; ready_in[3] = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (pattern_match[3]) begin
        data_in = 8'hA5;
        cyc();
        chk("capture_a5", 32'(data_out), 32'hA5);
        found = 1'b1;
      end else begin
        cyc();
      end
    end
    chk("rise_ch3_seen", 32'(found), 32'h1);
    data_in = 8'h3C; ready_in[0] = 1'b0; cycles(10);
    ready_in[0] = 1'b1; cycles(10);
    chk("capture_hold_other_ch", 32'(data_out), 32'hA5);

    // Reset mid-count restarts the full latency.
    ready_in[1] = 1'b1; cycles(4);
    rst = 1'b1; cyc();
    chk("midreset_pattern_match", 32'(pattern_match), 32'h0);
    chk("midreset_event_pending", 32'(event_pending), 32'h0);
    chk("midreset_data_out", 32'(data_out), 32'h0);
    rst = 1'b0;
    first = -1;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      if (first < 0 && pattern_match[1]) first = k;
    end
    chk("midreset_latency_ch1", 32'(first), 32'(2 + DEB));

    // Randomized traffic against the model.
    for (int k = 0; k < 600; k++) begin
      rst = ($urandom_range(0, 149) == 0);
      for (int i = 0; i < int'(NC); i++)
        if ($urandom_range(0, 7) == 0) ready_in[i] = ~ready_in[i];
      data_in    = BW'($urandom);
      f_wait     = 1'($urandom_range(0, 1));
      wait_ch    = 2'($urandom_range(0, 3));
      wait_mode  = wait_mode_t'($urandom_range(0, 3));
      wait_value = 1'($urandom_range(0, 1));
      cyc();
    end

    @(negedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
